// File: rtl/noc_dispatcher.sv
// Transmit-side NoC endpoint: packs user words into flits, queues them in a
// small register FIFO and streams them out as fixed-length AXI-Stream packets.
module noc_dispatcher #(
    parameter int         NOC_DW     = 512,
    parameter int         BYTE_DW    = 8,
    parameter int         USER_DW    = 32,
    parameter int         FIFO_DEPTH = 16,
    parameter int         PKT_FLITS  = 4,
    parameter logic [7:0] SRC_ID     = 8'd0,
    parameter logic [7:0] DEST_ID    = 8'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NOC_DW/BYTE_DW-1:0] ififo_wdata,
    input  logic                      ififo_wen,
    output logic                      ififo_rdy,
    output logic                      tx_tvalid,
    output logic [NOC_DW-1:0]         tx_tdata,
    output logic [NOC_DW/8-1:0]       tx_tstrb,
    output logic [NOC_DW/8-1:0]       tx_tkeep,
    output logic [7:0]                tx_tid,
    output logic [7:0]                tx_tdest,
    output logic [USER_DW-1:0]        tx_tuser,
    output logic                      tx_tlast,
    input  logic                      tx_tready
);
    localparam int WORD_DW = NOC_DW / BYTE_DW;
    localparam int LANES   = BYTE_DW;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FC_W    = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [FC_W-1:0]   LAST_FLIT = FC_W'(PKT_FLITS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [WORD_DW-1:0] partial_q [LANES];
    logic [WORD_DW-1:0] partial_d [LANES];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [FC_W-1:0]    flit_cnt_q, flit_cnt_d;
    logic [USER_DW-1:0] seq_q, seq_d;
    logic [NOC_DW-1:0]  fifo_mem_q [FIFO_DEPTH];

    logic [NOC_DW-1:0]  flit_assembled;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               push;
    logic               pop;
    logic               at_last_lane;
    logic               at_last_flit;

    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign at_last_lane = (lane_q == LAST_LANE);
    assign at_last_flit = (flit_cnt_q == LAST_FLIT);

    assign ififo_rdy = !rst && !fifo_full;
    assign accept    = ififo_wen && ififo_rdy;
    assign push      = accept && at_last_lane;
    assign pop       = tx_tvalid && tx_tready;

    // The top lane bypasses the partial register so a completed flit is
    // written into the FIFO on the same edge as its final word.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi == LANES - 1) begin : g_top
                assign flit_assembled[gi*WORD_DW +: WORD_DW] = ififo_wdata;
            end else begin : g_low
                assign flit_assembled[gi*WORD_DW +: WORD_DW] = partial_q[gi];
            end
        end
    endgenerate

    always_comb begin
        lane_d    = lane_q;
        partial_d = partial_q;
        if (accept) begin
            partial_d[lane_q] = ififo_wdata;
            lane_d            = at_last_lane ? '0 : lane_q + 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Packet framing: the sequence number advances only once a tlast flit is taken.
    always_comb begin
        flit_cnt_d = flit_cnt_q;
        seq_d      = seq_q;
        if (pop) begin
            if (at_last_flit) begin
                flit_cnt_d = '0;
                seq_d      = seq_q + 1'b1;
            end else begin
                flit_cnt_d = flit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flit_cnt_q <= '0;
            seq_q      <= '0;
            for (int i = 0; i < LANES; i++) begin
                partial_q[i] <= '0;
            end
        end else begin
            lane_q     <= lane_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flit_cnt_q <= flit_cnt_d;
            seq_q      <= seq_d;
            partial_q  <= partial_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= flit_assembled;
        end
    end

    assign tx_tvalid = !fifo_empty;
    assign tx_tdata  = fifo_mem_q[rd_ptr_q];
    assign tx_tlast  = at_last_flit && tx_tvalid;
    assign tx_tuser  = seq_q;
    assign tx_tstrb  = '1;
    assign tx_tkeep  = '1;
    assign tx_tid    = SRC_ID;
    assign tx_tdest  = DEST_ID;

endmodule

// File: tb/tb_noc_dispatcher.sv
// Directed bench for noc_dispatcher: drives inputs and samples outputs on the
// falling edge, tracking expected flits, framing and back-pressure in a small model.
module tb_noc_dispatcher;
    localparam int DEPTH = 16;
    localparam int PKT   = 4;
    localparam logic [7:0] SID = 8'h3C;
    localparam logic [7:0] DID = 8'hA5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  ififo_wdata = '0;
    logic         ififo_wen = 1'b0;
    logic         ififo_rdy;
    logic         tx_tvalid;
    logic [511:0] tx_tdata;
    logic [63:0]  tx_tstrb;
    logic [63:0]  tx_tkeep;
    logic [7:0]   tx_tid;
    logic [7:0]   tx_tdest;
    logic [31:0]  tx_tuser;
    logic         tx_tlast;
    logic         tx_tready = 1'b0;

    always #5 clk = ~clk;

    noc_dispatcher #(
        .NOC_DW(512), .BYTE_DW(8), .USER_DW(32), .FIFO_DEPTH(DEPTH),
        .PKT_FLITS(PKT), .SRC_ID(SID), .DEST_ID(DID)
    ) dut (
        .clk(clk), .rst(rst),
        .ififo_wdata(ififo_wdata), .ififo_wen(ififo_wen), .ififo_rdy(ififo_rdy),
        .tx_tvalid(tx_tvalid), .tx_tdata(tx_tdata), .tx_tstrb(tx_tstrb),
        .tx_tkeep(tx_tkeep), .tx_tid(tx_tid), .tx_tdest(tx_tdest),
        .tx_tuser(tx_tuser), .tx_tlast(tx_tlast), .tx_tready(tx_tready)
    );

    int tests = 0;
    int fails = 0;

    logic [511:0] exp_q[$];
    logic [63:0]  lane_buf [8];
    int           lane_n = 0;
    int           fcnt = 0;
    logic [31:0]  seq = '0;
    int           acc_n = 0;
    int           pop_n = 0;
    int           last_n = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int n);
        return {32'hC0DE0000 | 32'(n), 32'(n * 7 + 3)};
    endfunction

    task automatic model_clear();
        exp_q.delete();
        lane_n = 0;
        fcnt   = 0;
        seq    = '0;
        acc_n  = 0;
        pop_n  = 0;
        last_n = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; ififo_wen = 1'b0; ififo_wdata = '0; tx_tready = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("rst_rdy", ififo_rdy, 1'b0);
            chk("rst_tvalid", tx_tvalid, 1'b0);
            chk("rst_tlast", tx_tlast, 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("rst_rdy_after", ififo_rdy, 1'b1);
        model_clear();
    endtask

    // One clock cycle: set inputs at the falling edge, check what the DUT
    // presents, then advance the model as the next rising edge will.
    task automatic cycle(input logic wen, input logic [63:0] d, input logic rdy_in);
        logic         exp_rdy;
        logic [511:0] f;
        @(negedge clk);
        ififo_wen = wen; ififo_wdata = d; tx_tready = rdy_in;
        exp_rdy = (exp_q.size() < DEPTH);
        chk("ififo_rdy", ififo_rdy, exp_rdy);
        chk("tvalid", tx_tvalid, exp_q.size() != 0);
        chk("tlast", tx_tlast, (exp_q.size() != 0) && (fcnt == PKT - 1));
        chk("tstrb", tx_tstrb, {64{1'b1}});
        chk("tkeep", tx_tkeep, {64{1'b1}});
        chk("tid", tx_tid, SID);
        chk("tdest", tx_tdest, DID);
        if (exp_q.size() != 0) begin
            chk("tdata", tx_tdata, exp_q[0]);
            chk("tuser", tx_tuser, seq);
            if (rdy_in) begin
                pop_n++;
                if (fcnt == PKT - 1) begin
                    last_n++;
                    fcnt = 0;
                    seq  = seq + 1;
                end else begin
                    fcnt++;
                end
                exp_q.delete(0);
            end
        end
        if (wen && exp_rdy) begin
            acc_n++;
            lane_buf[lane_n] = d;
            if (lane_n == 7) begin
                for (int k = 0; k < 8; k++) f[64*k +: 64] = lane_buf[k];
                exp_q.push_back(f);
                lane_n = 0;
            end else begin
                lane_n++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: one flit, lanes carry 1..8
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 64'(k + 1), 1'b1);
            if (k == 7) chk("t1_latency", tx_tvalid, 1'b0);
        end
        cycle(1'b0, '0, 1'b1);
        for (int k = 0; k < 8; k++) chk($sformatf("t1_lane%0d", k), tx_tdata[64*k +: 64], 64'(k + 1));
        chk("t1_tvalid", tx_tvalid, 1'b1);
        chk("t1_tlast", tx_tlast, 1'b0);
        chk("t1_tuser", tx_tuser, 32'd0);
        cycle(1'b0, '0, 1'b1);
        chk("t1_drained", tx_tvalid, 1'b0);

        // T2: two packets of four flits each
        do_reset(1);
        for (int i = 0; i < 32; i++) cycle(1'b1, word_of(i), 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b1);
        chk("t2_pkt1_pops", pop_n, 4);
        chk("t2_pkt1_lasts", last_n, 1);
        for (int i = 32; i < 64; i++) cycle(1'b1, word_of(i), 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b1);
        chk("t2_pkt2_lasts", last_n, 2);
        chk("t2_tuser_next", tx_tuser, 32'd2);

        // T3: back-pressure fills the FIFO
        do_reset(1);
        for (int i = 0; i < 136; i++) cycle(1'b1, word_of(i), 1'b0);
        chk("t3_accepted", acc_n, 128);
        chk("t3_full_rdy", ififo_rdy, 1'b0);
        chk("t3_head", tx_tdata[63:0], word_of(0));

        // T4: drain sixteen flits
        for (int i = 0; i < 18; i++) cycle(1'b0, '0, 1'b1);
        chk("t4_pops", pop_n, 16);
        chk("t4_lasts", last_n, 4);
        chk("t4_empty", tx_tvalid, 1'b0);
        chk("t4_tuser_end", tx_tuser, 32'd4);

        // T5: simultaneous push and pop with 15 flits queued
        do_reset(1);
        for (int i = 0; i < 127; i++) cycle(1'b1, word_of(i), 1'b0);
        cycle(1'b1, word_of(127), 1'b1);
        cycle(1'b0, '0, 1'b0);
        chk("t5_count15_rdy", ififo_rdy, 1'b1);
        for (int i = 128; i < 136; i++) cycle(1'b1, word_of(i), 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("t5_full_rdy", ififo_rdy, 1'b0);
        chk("t5_head", tx_tdata[63:0], word_of(8));
        for (int i = 0; i < 18; i++) cycle(1'b0, '0, 1'b1);
        chk("t5_pops", pop_n, 17);
        chk("t5_empty", tx_tvalid, 1'b0);

        // T6: reset discards a partial flit
        do_reset(1);
        for (int i = 0; i < 5; i++) cycle(1'b1, word_of(500 + i), 1'b1);
        do_reset(1);
        for (int k = 0; k < 8; k++) cycle(1'b1, 64'hA0 + 64'(k), 1'b1);
        cycle(1'b0, '0, 1'b1);
        for (int k = 0; k < 8; k++) chk($sformatf("t6_lane%0d", k), tx_tdata[64*k +: 64], 64'hA0 + 64'(k));
        chk("t6_tuser", tx_tuser, 32'd0);
        chk("t6_tlast", tx_tlast, 1'b0);
        cycle(1'b0, '0, 1'b1);
        chk("t6_single", tx_tvalid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
